// File: rtl/carry_skip_seq_adder.sv
// Multi-cycle carry-skip adder: resolves one BLK-bit block per clock, LSB block first,
// bypassing the ripple carry for blocks whose bits all propagate and counting those skips.
//
// state | meaning
// IDLE  | waiting for start; results from the last operation held
// RUN   | one block resolved per clock, busy=1
// DONE  | single-cycle done pulse; start here is accepted back-to-back
module carry_skip_seq_adder #(
  parameter int WIDTH = 32,
  parameter int BLK   = 8
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               start,
  input  logic [WIDTH-1:0]                   a,
  input  logic [WIDTH-1:0]                   b,
  input  logic                               cin,
  output logic                               busy,
  output logic                               done,
  output logic [WIDTH-1:0]                   sum,
  output logic                               cout,
  output logic                               pout,
  output logic [$clog2(WIDTH/BLK+1)-1:0]     skip_cnt
);

  localparam int NBLK = WIDTH / BLK;
  localparam int IDXW = (NBLK > 1) ? $clog2(NBLK) : 1;
  localparam int CNTW = $clog2(NBLK + 1);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBLK - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             carry_q;
  logic [IDXW-1:0]  idx;

  logic             accept;
  logic             last_blk;
  logic [BLK-1:0]   p_blk;
  logic [BLK-1:0]   g_blk;
  logic [BLK:0]     c_int;
  logic [BLK-1:0]   sum_blk;
  logic             blk_skip;
  logic             carry_nxt;

  assign accept   = start && ((state == IDLE) || (state == DONE));
  assign last_blk = (idx == LAST_IDX);
  assign busy     = (state == RUN);
  assign done     = (state == DONE);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last_blk) state_nxt = DONE;
      DONE:    state_nxt = start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Block propagate/generate and the ripple chain seeded by the running carry
  always_comb begin
    p_blk    = a_q[int'(idx)*BLK +: BLK] ^ b_q[int'(idx)*BLK +: BLK];
    g_blk    = a_q[int'(idx)*BLK +: BLK] & b_q[int'(idx)*BLK +: BLK];
    c_int    = '0;
    c_int[0] = carry_q;
    for (int i = 0; i < BLK; i++) begin
      c_int[i+1] = g_blk[i] | (p_blk[i] & c_int[i]);
    end
    sum_blk  = p_blk ^ c_int[BLK-1:0];
    blk_skip = &p_blk;
    // When every bit propagates, the ripple result equals carry_q; take the bypass
    carry_nxt = blk_skip ? carry_q : c_int[BLK];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      carry_q  <= 1'b0;
      idx      <= '0;
      sum      <= '0;
      cout     <= 1'b0;
      pout     <= 1'b0;
      skip_cnt <= '0;
    end else if (accept) begin
      a_q      <= a;
      b_q      <= b;
      carry_q  <= cin;
      idx      <= '0;
      sum      <= '0;
      cout     <= 1'b0;
      pout     <= &(a ^ b);
      skip_cnt <= '0;
    end else if (state == RUN) begin
      sum[int'(idx)*BLK +: BLK] <= sum_blk;
      carry_q <= carry_nxt;
      if (blk_skip) skip_cnt <= skip_cnt + CNTW'(1);
      if (last_blk) begin
        cout <= carry_nxt;
        idx  <= '0;
      end else begin
        idx  <= idx + IDXW'(1);
      end
    end
  end

endmodule

// File: tb/tb_carry_skip_seq_adder.sv
// Directed and swept checks of carry_skip_seq_adder against an a+b+cin reference.
module tb_carry_skip_seq_adder;

  localparam int WIDTH = 32;
  localparam int BLK   = 8;
  localparam int NBLK  = WIDTH / BLK;
  localparam int CNTW  = $clog2(NBLK + 1);

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             cin = 1'b0;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             pout;
  logic [CNTW-1:0]  skip_cnt;

  int n_checks = 0;
  int n_errors = 0;

  carry_skip_seq_adder #(.WIDTH(WIDTH), .BLK(BLK)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .cout     (cout),
    .pout     (pout),
    .skip_cnt (skip_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge: present operands with start for one rising edge.
  task automatic launch(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb, input logic vc);
    a = va; b = vb; cin = vc; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts cycles (and busy cycles) until done is seen; bounded.
  task automatic wait_done(output int k, output int bc);
    k = 0; bc = 0;
    while (!done && k < 20) begin
      if (busy) bc++;
      @(negedge clk);
      k++;
    end
  endtask

  task automatic check_result(input string tag, input logic [WIDTH-1:0] va,
                              input logic [WIDTH-1:0] vb, input logic vc);
    logic [WIDTH:0]   full;
    logic [WIDTH-1:0] pv;
    int               sk;
    full = {1'b0, va} + {1'b0, vb} + {{WIDTH{1'b0}}, vc};
    pv   = va ^ vb;
    sk   = 0;
    for (int j = 0; j < NBLK; j++) if (&pv[j*BLK +: BLK]) sk++;
    check_val({tag, "_sum"},  64'(sum),      64'(full[WIDTH-1:0]));
    check_val({tag, "_cout"}, 64'(cout),     64'(full[WIDTH]));
    check_val({tag, "_pout"}, 64'(pout),     64'(&pv));
    check_val({tag, "_skip"}, 64'(skip_cnt), 64'(sk));
  endtask

  initial begin
    int k, bc, seen;
    logic [WIDTH-1:0] ra, rb;
    logic             rc;

    repeat (3) @(negedge clk);
    check_val("rst_busy", 64'(busy), 64'd0);
    check_val("rst_done", 64'(done), 64'd0);
    check_val("rst_sum",  64'(sum),  64'd0);
    check_val("rst_cout", 64'(cout), 64'd0);
    check_val("rst_pout", 64'(pout), 64'd0);
    check_val("rst_skip", 64'(skip_cnt), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed: latency and busy width
    launch(32'h0000_00FF, 32'h0000_0001, 1'b0);
    wait_done(k, bc);
    check_val("t1_latency", 64'(k), 64'd4);
    check_val("t1_busy_cycles", 64'(bc), 64'd4);
    check_val("t1_sum",  64'(sum), 64'h0000_0100);
    check_val("t1_cout", 64'(cout), 64'd0);
    check_val("t1_pout", 64'(pout), 64'd0);
    check_val("t1_skip", 64'(skip_cnt), 64'd0);
    @(negedge clk);
    check_val("t1_done_pulse", 64'(done), 64'd0);

    launch(32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
    wait_done(k, bc);
    check_val("t2_latency", 64'(k), 64'd4);
    check_val("t2_sum",  64'(sum), 64'h0);
    check_val("t2_cout", 64'(cout), 64'd1);
    check_val("t2_pout", 64'(pout), 64'd1);
    check_val("t2_skip", 64'(skip_cnt), 64'd4);
    @(negedge clk);

    launch(32'h1234_5678, 32'h8765_4321, 1'b0);
    wait_done(k, bc);
    check_val("t3_sum",  64'(sum), 64'h9999_9999);
    check_val("t3_cout", 64'(cout), 64'd0);
    check_val("t3_pout", 64'(pout), 64'd0);
    check_val("t3_skip", 64'(skip_cnt), 64'd0);
    @(negedge clk);

    launch(32'h8000_0000, 32'h8000_0000, 1'b0);
    wait_done(k, bc);
    check_val("t4_sum",  64'(sum), 64'h0);
    check_val("t4_cout", 64'(cout), 64'd1);
    check_val("t4_skip", 64'(skip_cnt), 64'd0);
    @(negedge clk);

    // Start during RUN is ignored
    launch(32'h0000_00FF, 32'h0000_0001, 1'b0);
    a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; cin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(k, bc);
    check_val("t5_latency", 64'(k), 64'd3);
    check_val("t5_sum",  64'(sum), 64'h0000_0100);
    check_val("t5_cout", 64'(cout), 64'd0);
    check_val("t5_skip", 64'(skip_cnt), 64'd0);

    // Start held in DONE: accepted back-to-back
    launch(32'h1, 32'h2, 1'b0);
    wait_done(k, bc);
    check_val("t6_latency", 64'(k), 64'd4);
    check_val("t6_sum", 64'(sum), 64'h3);
    @(negedge clk);

    // Reset mid-RUN aborts
    launch(32'h0000_0011, 32'h0000_0022, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_val("t7_busy", 64'(busy), 64'd0);
    check_val("t7_sum",  64'(sum), 64'd0);
    check_val("t7_cout", 64'(cout), 64'd0);
    check_val("t7_skip", 64'(skip_cnt), 64'd0);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (done) seen++;
      @(negedge clk);
    end
    check_val("t7_no_done", 64'(seen), 64'd0);
    launch(32'h0000_0011, 32'h0000_0022, 1'b0);
    wait_done(k, bc);
    check_val("t7_latency", 64'(k), 64'd4);
    check_result("t7_after", 32'h0000_0011, 32'h0000_0022, 1'b0);

    // Back-to-back sweep; every fourth vector forces all-propagate blocks
    for (int n = 0; n < 10000; n++) begin
      ra = $urandom;
      rb = $urandom;
      rc = 1'($urandom_range(0, 1));
      if ((n % 4) == 1) rb = ~ra;
      if ((n % 4) == 2) for (int j = 0; j < NBLK; j++)
        if ($urandom_range(0, 1) == 1) rb[j*BLK +: BLK] = ~ra[j*BLK +: BLK];
      launch(ra, rb, rc);
      wait_done(k, bc);
      if (k != 4) check_val("sweep_latency", 64'(k), 64'd4);
      check_result("sweep", ra, rb, rc);
      if (n_errors > 20) break;
    end
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/carry_skip_seq_adder.md
Name: carry_skip_seq_adder

Overview:
- Iterative carry-skip adder; consumes the operand pair whose propagate vector (a^b) and group propagate (&(a^b)) the propagate generator produces.
- Resolves carry and sum one BLK-bit block per clock.
- When a block's group propagate is 1, the carry bypasses the ripple path and the skip event is counted.
- Sits behind the adder datapath as the multi-cycle carry/sum resolution stage, driven by a start/done handshake.

Parameters:
- WIDTH, 32, operand and sum width; must be an integer multiple of BLK.
- BLK, 8, block width in bits; NBLK = WIDTH/BLK blocks, processed LSB block first.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  request; sampled only in IDLE or DONE.
- a  input  WIDTH  operand A; captured when start is accepted.
- b  input  WIDTH  operand B; captured when start is accepted.
- cin  input  1  carry in; captured when start is accepted.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse when sum/cout/pout/skip_cnt become valid.
- sum  output  WIDTH  a+b+cin mod 2^WIDTH.
- cout  output  1  carry out of MSB.
- pout  output  1  &(a^b) of the captured operands.
- skip_cnt  output  clog2(NBLK+1)  number of blocks whose carry was skipped.

Behaviour:
- Clock and reset:
  - One clock, clk; reset rst_n is synchronous, active-low.
  - While rst_n=0 at a rising edge: state=IDLE, busy=0, done=0, sum=0, cout=0, pout=0, skip_cnt=0, block index=0, internal operand and carry registers=0.
  - Reset mid-RUN aborts the operation: no done pulse, partial sum discarded (cleared to 0).
- States: IDLE, RUN, DONE.
- IDLE:
  - Outputs hold their last values.
  - On start=1: capture a, b, cin; clear sum, cout and skip_cnt; set index=0; pout <= &(a^b); go to RUN; busy=1 from the next cycle.
- RUN:
  - Each edge processes block k=index over bit range [k*BLK +: BLK].
  - p_k = a_k^b_k; g_k = a_k&b_k; internal carries rippled from carry-in c.
  - sum block <= p_k ^ {internal carries, c}.
  - If &p_k=1: carry <= c (skip path) and skip_cnt += 1.
  - Else: carry <= ripple carry-out of the block.
  - Both paths must give the identical carry value; the skip path is the selected one when &p_k=1.
  - index += 1.
  - start is ignored in RUN.
- RUN exit:
  - On the edge that processes block NBLK-1: cout <= final carry; state -> DONE; busy <= 0; done <= 1.
- DONE:
  - Lasts exactly one cycle; done=1 during it.
  - Next edge: done <= 0, state -> IDLE.
  - If start=1 in DONE, it is accepted exactly as in IDLE (back-to-back) and state goes to RUN.
- Timing:
  - Latency: start sampled at edge E0; blocks written at E1..E_NBLK; done high in the cycle following E_NBLK, i.e. NBLK cycles after acceptance (4 for the defaults).
  - Throughput: one result per NBLK+1 cycles with back-to-back starts.
- Output validity:
  - sum, cout, pout and skip_cnt are valid from the done cycle.
  - They hold until the next accepted start, which clears sum, cout and skip_cnt and reloads pout.
  - They are undefined-to-consumer, but deterministic, during RUN.
- Arithmetic:
  - Unsigned, modulo 2^WIDTH; cout is bit WIDTH of the true sum.
  - skip_cnt saturates naturally at NBLK (maximum reachable value).
- Input stability: a, b and cin changes after capture have no effect.

Test Plan:
- a=0x000000FF, b=0x00000001, cin=0, start -> done exactly 4 cycles later; sum=0x00000100, cout=0, pout=0, skip_cnt=0; busy high for 4 cycles.
- a=0xFFFFFFFF, b=0x00000000, cin=1 -> sum=0x00000000, cout=1, pout=1, skip_cnt=4.
- a=0x12345678, b=0x87654321, cin=0 -> sum=0x99999999, cout=0, pout=0, skip_cnt=0. Then a=0x80000000, b=0x80000000, cin=0 -> sum=0, cout=1, skip_cnt=0.
- Start pulsed again during RUN with different operands -> ignored; first result delivered unchanged. Start held in the DONE cycle with a=1, b=2, cin=0 -> accepted; sum=3 after 4 more cycles.
- rst_n=0 for one edge two cycles after start -> busy=0, no done pulse, sum=0, cout=0, skip_cnt=0; next start completes normally.
- Random sweep of 10k vectors, back-to-back -> sum/cout match the {a+b+cin} model; pout matches &(a^b); skip_cnt equals the count of blocks with all-ones propagate.
